// File: rtl/asyn_fifo_reader.sv
// Read-side front end for an asynchronous FIFO: pops words into a 2-entry skid buffer and presents them as valid/ready.
// Optional feature: define ASYN_FIFO_READER_CNT_EN to add the 16-bit word_cnt transfer counter output.
module asyn_fifo_reader #(
  parameter int word_width = 8
) (
  input  logic                  r_clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  empty,
  input  logic [word_width-1:0] data_out,
  output logic                  rd,
  output logic [word_width-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy
`ifdef ASYN_FIFO_READER_CNT_EN
  ,
  output logic [15:0]           word_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ACTIVE, STALL} state_t;

  state_t                r_state;
  logic [word_width-1:0] r_buf0;
  logic [word_width-1:0] r_buf1;
  logic [1:0]            r_held;
  logic                  r_inflight;
  logic                  r_m_valid;

  logic                  w_pop;
  logic [1:0]            w_occ;
  logic [1:0]            w_held_nxt;
  logic [1:0]            w_occ_nxt;

  assign w_pop = r_m_valid & m_ready;
  assign w_occ = r_held + {1'b0, r_inflight};
  // A leaving word frees a slot at the same edge, so a full buffer may still issue a read.
  assign rd    = reset_n & enable & ~empty & ((w_occ < 2'd2) | w_pop);

  always_comb begin
    w_held_nxt = r_held;
    case ({r_inflight, w_pop})
      2'b10:   w_held_nxt = r_held + 2'd1;
      2'b01:   w_held_nxt = r_held - 2'd1;
      default: w_held_nxt = r_held;
    endcase
  end

  assign w_occ_nxt = w_held_nxt + {1'b0, rd};

  always_ff @(posedge r_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_buf0     <= '0;
      r_buf1     <= '0;
      r_held     <= 2'd0;
      r_inflight <= 1'b0;
      r_m_valid  <= 1'b0;
    end else begin
      r_inflight <= rd;
      r_held     <= w_held_nxt;
      r_m_valid  <= (w_held_nxt != 2'd0);
      // Entry 0 is always the oldest word; a capture lands behind whatever remains after a pop.
      if (w_pop) begin
        if (r_inflight && (r_held == 2'd1)) r_buf0 <= data_out;
        else                                r_buf0 <= r_buf1;
        if (r_inflight && (r_held == 2'd2)) r_buf1 <= data_out;
      end else if (r_inflight) begin
        if (r_held == 2'd0) r_buf0 <= data_out;
        else                r_buf1 <= data_out;
      end
      if (w_occ_nxt == 2'd0)       r_state <= IDLE;
      else if (w_held_nxt == 2'd2) r_state <= STALL;
      else                         r_state <= ACTIVE;
    end
  end

  assign m_data  = r_buf0;
  assign m_valid = r_m_valid;
  assign busy    = (r_state != IDLE);

`ifdef ASYN_FIFO_READER_CNT_EN
  logic [15:0] r_word_cnt;

  always_ff @(posedge r_clk or negedge reset_n) begin
    if (!reset_n)   r_word_cnt <= 16'd0;
    else if (w_pop) r_word_cnt <= r_word_cnt + 16'd1;
  end

  assign word_cnt = r_word_cnt;
`endif

endmodule

// File: tb/tb_asyn_fifo_reader.sv
// Directed bench for asyn_fifo_reader: a small FIFO model feeds the reader and delivered words are compared to hand-computed lists.
module tb_asyn_fifo_reader;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic       empty;
  logic [7:0] data_out;
  logic       rd;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       busy;
`ifdef ASYN_FIFO_READER_CNT_EN
  logic [15:0] word_cnt;
`endif

  asyn_fifo_reader #(.word_width(8)) dut (
    .r_clk    (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .empty    (empty),
    .data_out (data_out),
    .rd       (rd),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .busy     (busy)
`ifdef ASYN_FIFO_READER_CNT_EN
    ,
    .word_cnt (word_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: the popped word appears on data_out after the accepting edge; otherwise junk.
  logic [7:0] mem [0:63];
  int wp = 0;
  int rp = 0;
  assign empty = (wp == rp);

  always @(posedge clk) begin
    if (rd) begin
      data_out <= mem[rp[5:0]];
      rp       <= rp + 1;
    end else begin
      data_out <= 8'($urandom);
    end
  end

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] rx_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic push(input logic [7:0] w);
    mem[wp[5:0]] = w;
    wp = wp + 1;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drain(input int maxc);
    rx_q.delete();
    for (int i = 0; i < maxc; i++) begin
      #1;
      if (m_valid && m_ready) rx_q.push_back(m_data);
      tick();
    end
  endtask

  initial begin
    int n_rd;
    int bad;
    int bad_rd;
    int bad_mv;
    int bad_bz;

    // Reset state, with a loaded FIFO and enable high
    reset_n = 1'b0;
    enable  = 1'b1;
    m_ready = 1'b1;
    push(8'd104); push(8'd105); push(8'd95);
    #1;
    chk("rst_rd", rd, 0);
    chk("rst_mvalid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mdata", m_data, 0);

    // Streaming: 104,105,95 back to back, m_valid two edges after the first rd
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("s1_rd_first", rd, 1);
    chk("s1_mvalid_pre", m_valid, 0);
    tick();
    chk("s1_mvalid_e1", m_valid, 0);
    chk("s1_busy_e1", busy, 1);
    tick();
    chk("s1_mvalid_e2", m_valid, 1);
    chk("s1_word0", m_data, 104);
    tick();
    chk("s1_word1", m_data, 105);
    tick();
    chk("s1_word2", m_data, 95);
    chk("s1_mvalid_e4", m_valid, 1);
    tick();
    chk("s1_mvalid_end", m_valid, 0);
    chk("s1_busy_end", busy, 0);

    // Back-pressure: only two reads while stalled, head word held steady
    m_ready = 1'b0;
    push(8'd116); push(8'd104); push(8'd101); push(8'd114);
    n_rd = 0;
    bad  = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (rd) n_rd++;
      if (i >= 2 && (!m_valid || m_data != 8'd116)) bad++;
      tick();
    end
    chk("s2_rd_pulses", n_rd, 2);
    chk("s2_hold_unstable", bad, 0);
    chk("s2_mvalid", m_valid, 1);
    chk("s2_mdata", m_data, 116);
    chk("s2_busy", busy, 1);
    m_ready = 1'b1;
    drain(8);
    chk("s2_count", rx_q.size(), 4);
    chk("s2_word0", rx_q[0], 116);
    chk("s2_word1", rx_q[1], 104);
    chk("s2_word2", rx_q[2], 101);
    chk("s2_word3", rx_q[3], 114);
    chk("s2_busy_end", busy, 0);

    // Empty FIFO: nothing happens
    bad_rd = 0; bad_mv = 0; bad_bz = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (rd)      bad_rd++;
      if (m_valid) bad_mv++;
      if (busy)    bad_bz++;
      tick();
    end
    chk("s3_rd_seen", bad_rd, 0);
    chk("s3_mvalid_seen", bad_mv, 0);
    chk("s3_busy_seen", bad_bz, 0);

    // Enable drops right after the read of 79; 200 must stay in the FIFO
    push(8'd79); push(8'd200);
    #1;
    chk("s4_rd", rd, 1);
    tick();
    chk("s4_busy_inflight", busy, 1);
    enable = 1'b0;
    n_rd = 0;
    rx_q.delete();
    for (int i = 0; i < 5; i++) begin
      #1;
      if (rd) n_rd++;
      if (m_valid && m_ready) rx_q.push_back(m_data);
      tick();
    end
    chk("s4_rd_after_drop", n_rd, 0);
    chk("s4_count", rx_q.size(), 1);
    chk("s4_word", rx_q[0], 79);
    chk("s4_busy_end", busy, 0);

    // Reset with two words held: 200 and 201 are lost, 105 comes out first
    enable  = 1'b1;
    m_ready = 1'b0;
    push(8'd201); push(8'd105);
    repeat (4) tick();
    chk("s5_mvalid_held", m_valid, 1);
    chk("s5_mdata_held", m_data, 200);
    chk("s5_busy_held", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("s5_rst_mvalid", m_valid, 0);
    chk("s5_rst_busy", busy, 0);
    chk("s5_rst_rd", rd, 0);
    chk("s5_rst_mdata", m_data, 0);
    tick();
    reset_n = 1'b1;
    m_ready = 1'b1;
    drain(6);
    chk("s5_count", rx_q.size(), 1);
    chk("s5_first", rx_q[0], 105);

`ifdef ASYN_FIFO_READER_CNT_EN
    // Transfer counter: 105 plus 13 more since reset, then wrap
    for (int i = 1; i <= 13; i++) push(8'(i));
    drain(20);
    chk("c_count", rx_q.size(), 13);
    chk("c_word_cnt14", word_cnt, 14);
    force dut.r_word_cnt = 16'hFFFF;
    #1;
    release dut.r_word_cnt;
    push(8'd42);
    drain(6);
    chk("c_wrap_count", rx_q.size(), 1);
    chk("c_word_cnt_wrap", word_cnt, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
